alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// - Byte-serial front end for the 8-bit ALU. Collects opcode, operand A and operand B over one 8-bit input bus.
// - Drives the ALU operand/opcode lines and waits the ALU latency.
// - Captures result and flags, then presents them over a valid/ready output handshake.
// - Sits between the top-level pins and the ALU core.
// PARAMETERS
// - OP_W    4  ALU opcode width (opcode byte bits [OP_W-1:0])
// - NUM_OPS 8  legal opcodes 0..NUM_OPS-1; others are illegal
// - FLAG_W  4  ALU flag vector width
// - LAT     1  ALU cycles from alu_start to valid result, 0..15
// PORTS
// - clk         in   1       clock, rising edge
// - rst_n       in   1       asynchronous active-low reset
// - ena         in   1       design enable; low = freeze
// - in_data     in   8       opcode/operand byte
// - in_valid    in   1       in_data valid
// - in_ready    out  1       byte accepted when in_valid & in_ready
// - alu_a       out  8       operand A to ALU (registered)
// - alu_b       out  8       operand B to ALU (registered)
// - alu_op      out  OP_W    opcode to ALU (registered)
// - alu_start   out  1       one-cycle launch pulse to ALU
// - alu_result  in   8       ALU result
// - alu_flags   in   FLAG_W  ALU flags (C,Z,N,V)
// - res_data    out  8       captured result
// - res_flags   out  FLAG_W  captured flags
// - res_err     out  1       1 = illegal opcode, no execution
// - res_valid   out  1       result available
// - res_ready   in   1       consumer takes result
// - busy        out  1       state != S_OP
// BEHAVIOUR
// - Reset (async, rst_n=0): state=S_OP; counter=0; all registered outputs 0.
//   Registered outputs: alu_a, alu_b, alu_op, alu_start, res_data, res_flags, res_err, res_valid.
// - in_ready=0 while in reset.
// - FSM: S_OP -> S_A -> S_B -> S_EXEC -> S_RES -> S_OP.
// - in_ready = ena & (state in S_OP/S_A/S_B); combinational.
// - S_OP, on accept: alu_op <= in_data[OP_W-1:0]. Bits [7:OP_W] ignored, except bit7 when ACC_CHAIN_EN is defined.
//   - Legal opcode: next state is S_A.
//   - Illegal opcode (>=NUM_OPS): next state is S_RES with res_data=0, res_flags=0, res_err=1, res_valid=1. No alu_start.
// - S_A, on accept: alu_a <= in_data; go to S_B.
// - S_B, on accept: alu_b <= in_data; go to S_EXEC; counter <= LAT.
// - S_EXEC:
//   - alu_start=1 in the first S_EXEC cycle only.
//   - Counter decrements each cycle.
//   - At the edge where counter==0: res_data <= alu_result, res_flags <= alu_flags, res_err <= 0, res_valid <= 1; go to S_RES.
//   - Latency: res_valid rises LAT+1 edges after the B-accept edge.
// - S_RES:
//   - res_* held stable; in_ready=0.
//   - On res_valid & res_ready: res_valid <= 0 and go to S_OP.
//   - First new byte can be accepted in the following cycle.
// - ena=0: FSM, counter and all registers freeze (including mid-S_EXEC); in_ready=0.
//   - A held alu_start stays high until ena returns.
//   - The res_ready handshake is ignored while ena=0.
// - Operand registers keep their last values between transactions.
// - Reset mid-operation aborts immediately; the partial transaction is discarded.
// CONFIGURATION
// - ACC_CHAIN_EN defined:
//   - Opcode bit7=1 with a legal opcode: alu_a <= res_data of the last completed op; go S_OP -> S_B, skipping S_A.
//   - Chained value after reset is 0; an illegal-op result (0) also chains.
// - ACC_CHAIN_EN undefined: bit7 ignored; S_A is always visited.
// TESTING (bench ALU model: op0=ADD, op1=SUB, LAT=1)
// 1. Bytes 0x00,0x12,0x34, res_ready=1
//    -> alu_start one cycle; res_valid 2 edges after B accept.
//    -> res_data=0x46, res_err=0; busy low the cycle after the handshake.
// 2. Bytes 0x01,0x10,0x20, res_ready=0 for 5 cycles
//    -> res_data=0xF0 held, N flag set; in_ready=0 throughout.
//    -> Raise res_ready: S_OP next cycle.
// 3. Opcode 0x0F
//    -> no alu_start; next cycle res_valid=1, res_data=0, res_err=1.
//    -> Following byte is treated as an opcode.
// 4. ena=0 for 3 cycles during S_B with in_valid=1 -> byte not taken.
//    ena=0 in S_EXEC -> alu_start held, no result until ena=1; final result still correct.
// 5. rst_n=0 during S_EXEC
//    -> res_valid, alu_start and operand outputs 0 immediately.
//    -> in_ready=1 first cycle after release (ena=1).
// 6. ACC_CHAIN_EN: 0x00,0xF0,0x05 -> 0xF5; then 0x80,0x01 -> 0xF6.
//    Without the macro: 0x80,0x01,0x02 -> 0x03.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Byte-serial front end for the 8-bit ALU: collects opcode, A and B, launches the ALU and holds the result.
// Optional feature: define ACC_CHAIN_EN so opcode bit 7 reuses the last result as operand A.
module alu_op_sequencer #(
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 8,
    parameter int FLAG_W  = 4,
    parameter int LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic [7:0]        alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [7:0]        res_data,
    output logic [FLAG_W-1:0] res_flags,
    output logic              res_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam logic [3:0]  LAT_C     = 4'(LAT);
    localparam logic [31:0] NUM_OPS_U = 32'(NUM_OPS);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              alu_start_q, alu_start_d;
    logic [7:0]        res_data_q, res_data_d;
    logic [FLAG_W-1:0] res_flags_q, res_flags_d;
    logic              res_err_q, res_err_d;
    logic              res_valid_q, res_valid_d;

    logic [OP_W-1:0]   op_byte;
    logic              op_legal;
    logic              in_ready_int;
    logic              accept;

    assign op_byte  = in_data[OP_W-1:0];
    assign op_legal = ({{(32-OP_W){1'b0}}, op_byte} < NUM_OPS_U);

    // rst_n gates in_ready so nothing looks acceptable while reset is held.
    assign in_ready_int = rst_n & ena &
                          ((state_q == S_OP) || (state_q == S_A) || (state_q == S_B));
    assign accept       = in_valid & in_ready_int;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_start_d = alu_start_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;

        if (ena) begin
            case (state_q)
                S_OP: begin
                    if (accept) begin
                        alu_op_d = op_byte;
                        if (!op_legal) begin
                            res_data_d  = '0;
                            res_flags_d = '0;
                            res_err_d   = 1'b1;
                            res_valid_d = 1'b1;
                            state_d     = S_RES;
                        end
`ifdef ACC_CHAIN_EN
                        else if (in_data[7]) begin
                            alu_a_d = res_data_q;
                            state_d = S_B;
                        end
`endif
                        else begin
                            state_d = S_A;
                        end
                    end
                end
                S_A: begin
                    if (accept) begin
                        alu_a_d = in_data;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (accept) begin
                        alu_b_d     = in_data;
                        cnt_d       = LAT_C;
                        alu_start_d = 1'b1;
                        state_d     = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The launch pulse only lasts for the first enabled EXEC cycle.
                    alu_start_d = 1'b0;
                    if (cnt_q == 4'd0) begin
                        res_data_d  = alu_result;
                        res_flags_d = alu_flags;
                        res_err_d   = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = S_RES;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_RES: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = S_OP;
                    end
                end
                default: begin
                    state_d = S_OP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OP;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_start_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_start_q <= alu_start_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready  = in_ready_int;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_start = alu_start_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign res_err   = res_err_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != S_OP);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small LAT=1 ALU stub (op0=ADD, op1=SUB, flags {C,Z,N,V}).
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic       alu_start;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       res_err, res_valid, res_ready, busy;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.OP_W(4), .NUM_OPS(8), .FLAG_W(4), .LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .res_data(res_data), .res_flags(res_flags), .res_err(res_err),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
    );

    // ALU stub: one-cycle latency, result registered on alu_start.
    logic [8:0] calc_wide;
    logic [7:0] calc_res;
    logic [3:0] calc_flags;
    logic       calc_v;
    always_comb begin
        calc_wide = '0;
        calc_v    = 1'b0;
        case (alu_op)
            4'd0: begin
                calc_wide = {1'b0, alu_a} + {1'b0, alu_b};
                calc_v    = (alu_a[7] == alu_b[7]) && (calc_wide[7] != alu_a[7]);
            end
            4'd1: begin
                calc_wide = {1'b0, alu_a} - {1'b0, alu_b};
                calc_v    = (alu_a[7] != alu_b[7]) && (calc_wide[7] != alu_a[7]);
            end
            default: calc_wide = '0;
        endcase
        calc_res   = calc_wide[7:0];
        calc_flags = {calc_wide[8], (calc_res == 8'd0), calc_res[7], calc_v};
    end

    always_ff @(posedge clk) begin
        if (alu_start) begin
            alu_result <= calc_res;
            alu_flags  <= calc_flags;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Offer one byte at a negedge; returns at the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_d, input logic [3:0] exp_f);
        send(op);
        send(a);
        send(b);
        wait_res(tag);
        chk({tag, "_data"}, 32'(res_data), 32'(exp_d));
        chk({tag, "_flags"}, 32'(res_flags), 32'(exp_f));
        chk({tag, "_err"}, 32'(res_err), 32'd0);
        $display("[TB] txn %s op=%02h a=%02h b=%02h res=%02h flags=%h", tag, op, a, b, res_data, res_flags);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        res_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        rst_n = 1'b1;

        // 1: ADD 0x12+0x34, res_ready held high
        send(8'h00);
        send(8'h12);
        send(8'h34);
        chk("t1_start_hi", 32'(alu_start), 32'd1);
        chk("t1_in_ready_exec", 32'(in_ready), 32'd0);
        tick();
        chk("t1_start_lo", 32'(alu_start), 32'd0);
        chk("t1_valid_early", 32'(res_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_data", 32'(res_data), 32'h46);
        chk("t1_err", 32'(res_err), 32'd0);
        chk("t1_flags", 32'(res_flags), 32'h0);
        $display("[TB] txn t1 op=00 a=12 b=34 res=%02h flags=%h", res_data, res_flags);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_valid_after", 32'(res_valid), 32'd0);

        // 2: SUB 0x10-0x20 with the consumer stalling
        res_ready = 1'b0;
        send(8'h01);
        send(8'h10);
        send(8'h20);
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(res_valid), 32'd1);
            chk("t2_hold_data", 32'(res_data), 32'hF0);
            chk("t2_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("t2_n_flag", 32'(res_flags[1]), 32'd1);
        chk("t2_flags", 32'(res_flags), 32'hA);
        $display("[TB] txn t2 op=01 a=10 b=20 res=%02h flags=%h", res_data, res_flags);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_valid_after", 32'(res_valid), 32'd0);

        // 3: illegal opcode 0x0F, then the next byte must be an opcode
        send(8'h0F);
        chk("t3_valid", 32'(res_valid), 32'd1);
        chk("t3_data", 32'(res_data), 32'h0);
        chk("t3_err", 32'(res_err), 32'd1);
        chk("t3_flags", 32'(res_flags), 32'h0);
        chk("t3_no_start", 32'(alu_start), 32'd0);
        $display("[TB] txn t3 op=0F err=%0d", res_err);
        run_op("t3_next", 8'h00, 8'h01, 8'h02, 8'h03, 4'h0);

        // Opcode boundaries: 0x08 is the first illegal, 0x07 the last legal
        send(8'h08);
        chk("b8_err", 32'(res_err), 32'd1);
        chk("b8_valid", 32'(res_valid), 32'd1);
        $display("[TB] txn b8 op=08 err=%0d", res_err);
        send(8'h07);
        chk("b7_no_result", 32'(res_valid), 32'd0);
        chk("b7_in_ready", 32'(in_ready), 32'd1);
        send(8'h33);
        send(8'h44);
        wait_res("b7");
        chk("b7_err", 32'(res_err), 32'd0);
        chk("b7_flags", 32'(res_flags), 32'h4);
        $display("[TB] txn b7 op=07 res=%02h flags=%h", res_data, res_flags);

        // 4: freeze with ena=0 in S_B, in S_EXEC and in S_RES
        send(8'h00);
        send(8'h05);
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h07;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_b_in_ready", 32'(in_ready), 32'd0);
            chk("t4_b_busy", 32'(busy), 32'd1);
        end
        ena = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_start", 32'(alu_start), 32'd1);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_start_held", 32'(alu_start), 32'd1);
            chk("t4_no_result", 32'(res_valid), 32'd0);
        end
        ena = 1'b1;
        tick();
        chk("t4_start_drop", 32'(alu_start), 32'd0);
        tick();
        chk("t4_valid", 32'(res_valid), 32'd1);
        chk("t4_data", 32'(res_data), 32'h0C);
        $display("[TB] txn t4 op=00 a=05 b=07 res=%02h", res_data);
        ena = 1'b0;
        tick();
        chk("t4_res_frozen", 32'(res_valid), 32'd1);
        ena = 1'b1;
        tick();
        chk("t4_res_taken", 32'(res_valid), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);

        // 5: reset while executing
        send(8'h00);
        send(8'h11);
        send(8'h22);
        chk("t5_pre_start", 32'(alu_start), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(res_valid), 32'd0);
        chk("t5_rst_start", 32'(alu_start), 32'd0);
        chk("t5_rst_a", 32'(alu_a), 32'd0);
        chk("t5_rst_b", 32'(alu_b), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t5_no_result", 32'(res_valid), 32'd0);
        $display("[TB] txn t5 reset mid-exec");

        // 6: accumulator chaining (or bit 7 ignored)
`ifdef ACC_CHAIN_EN
        send(8'h80);
        send(8'h01);
        wait_res("t6_rst");
        chk("t6_rst_data", 32'(res_data), 32'h01);
        $display("[TB] txn t6_rst op=80 b=01 res=%02h", res_data);
        run_op("t6_a", 8'h00, 8'hF0, 8'h05, 8'hF5, 4'h2);
        send(8'h80);
        send(8'h01);
        wait_res("t6_b");
        chk("t6_b_data", 32'(res_data), 32'hF6);
        chk("t6_b_flags", 32'(res_flags), 32'h2);
        $display("[TB] txn t6_b op=80 b=01 res=%02h", res_data);
`else
        run_op("t6", 8'h80, 8'h01, 8'h02, 8'h03, 4'h0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
